// File: rtl/uart_apb_pkg.sv
// rtl/uart_apb_pkg.sv - UART register map, init constants and sequencer state type
// Contents: register offsets, init register values, LSR.THRE bit index, state_t.
package uart_apb_pkg;

  // Register offsets from the UART base address
  localparam int OFF_THR = 0;
  localparam int OFF_DLL = 0;
  localparam int OFF_DLM = 1;
  localparam int OFF_FCR = 2;
  localparam int OFF_LCR = 3;
  localparam int OFF_LSR = 5;

  // Init values: divisor latch access + 8N1, plain 8N1, FIFO enable + clear both FIFOs
  localparam logic [7:0] LCR_DLAB_8N1 = 8'h83;
  localparam logic [7:0] LCR_8N1      = 8'h03;
  localparam logic [7:0] FCR_INIT     = 8'h07;

  localparam int LSR_THRE = 5;

  typedef enum logic [3:0] {
    ST_UNINIT,
    ST_INIT_LCR_DLAB,
    ST_INIT_DLL,
    ST_INIT_DLM,
    ST_INIT_LCR,
    ST_INIT_FCR,
    ST_READY,
    ST_POLL_LSR,
    ST_WR_THR
  } state_t;

endpackage

// File: rtl/apb_master_xfer.sv
// rtl/apb_master_xfer.sv - single APB transfer engine (SETUP/ACCESS phases, byte lane steering)
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   req, addr, wdata, write     transfer request, sampled only while idle
//   idle                        no transfer in flight (PSEL low)
//   done, rdata, err            completion strobe, lane-selected read byte, PSLVERR at completion
//   paddr..pstrb                APB master outputs (registered)
//   pready, prdata, pslverr     APB slave responses
module apb_master_xfer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [7:0]          wdata,
  input  logic                write,
  output logic                idle,
  output logic                done,
  output logic [7:0]          rdata,
  output logic                err,
  output logic [ADDR_W-1:0]   paddr,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic                pready,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pslverr
);

  localparam int LANES  = DATA_W / 8;
  localparam int LANE_W = $clog2(LANES);

  logic [LANE_W-1:0] lane;

  assign lane  = paddr[LANE_W-1:0];
  assign idle  = ~psel;
  assign done  = psel & penable & pready;
  assign err   = done & pslverr;
  assign rdata = prdata[{lane, 3'b000} +: 8];

  // Phase is encoded directly in psel/penable: idle (0,0), SETUP (1,0), ACCESS (1,1).
  // A request is only taken while idle, so consecutive transfers always see a PSEL=0 cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      paddr   <= '0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      pwdata  <= '0;
      pstrb   <= '0;
    end else if (!psel) begin
      if (req) begin
        psel   <= 1'b1;
        paddr  <= addr;
        pwrite <= write;
        pwdata <= {LANES{wdata}};
        pstrb  <= write ? ({{(LANES-1){1'b0}}, 1'b1} << addr[LANE_W-1:0]) : '0;
      end
    end else if (!penable) begin
      penable <= 1'b1;
    end else if (pready) begin
      psel    <= 1'b0;
      penable <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_apb_tx_master.sv
// rtl/uart_apb_tx_master.sv - APB master that initialises a UART and streams bytes into its THR
// Ports:
//   PCLK_i, PRESETn_i            clock, synchronous active-low reset
//   cfg_start_i, divisor_i       start (or restart) the init sequence with this baud divisor
//   tx_valid_i/tx_data_i/tx_ready_o  byte source handshake
//   init_done_o, busy_o, err_o   status (err_o sticky until reset or cfg_start_i)
//   PADDR_o..PSTRB_o, PREADY_i, PRDATA_i, PSLVERR_i  APB master port to the UART
module uart_apb_tx_master
  import uart_apb_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                FIFO_DEPTH = 16,
  parameter int                POLL_LIMIT = 1024
) (
  input  logic                PCLK_i,
  input  logic                PRESETn_i,
  input  logic                cfg_start_i,
  input  logic [15:0]         divisor_i,
  input  logic                tx_valid_i,
  input  logic [7:0]          tx_data_i,
  output logic                tx_ready_o,
  output logic                init_done_o,
  output logic                busy_o,
  output logic                err_o,
  output logic [ADDR_W-1:0]   PADDR_o,
  output logic                PPROT_o,
  output logic                PSEL_o,
  output logic                PENABLE_o,
  output logic                PWRITE_o,
  output logic [DATA_W-1:0]   PWDATA_o,
  output logic [DATA_W/8-1:0] PSTRB_o,
  input  logic                PREADY_i,
  input  logic [DATA_W-1:0]   PRDATA_i,
  input  logic                PSLVERR_i
);

  localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
  localparam int POLL_W = $clog2(POLL_LIMIT + 1);

  state_t            state;
  logic              init_done;
  logic              err;
  logic              restart_pend;
  logic              hold_valid;
  logic [7:0]        hold_data;
  logic [15:0]       div_q;
  logic [CRED_W-1:0] credits;
  logic [POLL_W-1:0] poll_cnt;

  logic              req;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic              x_idle;
  logic              x_done;
  logic              x_err;
  logic [7:0]        x_rdata;
  logic              thr_ok;
  logic              accept;

  apb_master_xfer #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_xfer (
    .clk     (PCLK_i),
    .resetn  (PRESETn_i),
    .req     (req),
    .addr    (req_addr),
    .wdata   (req_wdata),
    .write   (req_write),
    .idle    (x_idle),
    .done    (x_done),
    .rdata   (x_rdata),
    .err     (x_err),
    .paddr   (PADDR_o),
    .psel    (PSEL_o),
    .penable (PENABLE_o),
    .pwrite  (PWRITE_o),
    .pwdata  (PWDATA_o),
    .pstrb   (PSTRB_o),
    .pready  (PREADY_i),
    .prdata  (PRDATA_i),
    .pslverr (PSLVERR_i)
  );

  // Every state except UNINIT/READY owns exactly one APB transfer. A pending restart
  // holds off new transfers so the sequencer can jump back to the start of init.
  always_comb begin
    req       = 1'b0;
    req_write = 1'b1;
    req_wdata = 8'h00;
    req_addr  = BASE_ADDR;
    case (state)
      ST_INIT_LCR_DLAB: begin
        req       = 1'b1;
        req_addr  = BASE_ADDR + ADDR_W'(OFF_LCR);
        req_wdata = LCR_DLAB_8N1;
      end
      ST_INIT_DLL: begin
        req       = 1'b1;
        req_addr  = BASE_ADDR + ADDR_W'(OFF_DLL);
        req_wdata = div_q[7:0];
      end
      ST_INIT_DLM: begin
        req       = 1'b1;
        req_addr  = BASE_ADDR + ADDR_W'(OFF_DLM);
        req_wdata = div_q[15:8];
      end
      ST_INIT_LCR: begin
        req       = 1'b1;
        req_addr  = BASE_ADDR + ADDR_W'(OFF_LCR);
        req_wdata = LCR_8N1;
      end
      ST_INIT_FCR: begin
        req       = 1'b1;
        req_addr  = BASE_ADDR + ADDR_W'(OFF_FCR);
        req_wdata = FCR_INIT;
      end
      ST_POLL_LSR: begin
        req       = 1'b1;
        req_write = 1'b0;
        req_addr  = BASE_ADDR + ADDR_W'(OFF_LSR);
      end
      ST_WR_THR: begin
        req       = 1'b1;
        req_addr  = BASE_ADDR + ADDR_W'(OFF_THR);
        req_wdata = hold_data;
      end
      default: ;
    endcase
    if (cfg_start_i || restart_pend) req = 1'b0;
  end

  // The holding register frees in the cycle its THR write completes, so a new byte can
  // be taken in that same cycle without a bubble.
  assign thr_ok     = (state == ST_WR_THR) & x_done & ~PSLVERR_i;
  assign tx_ready_o = init_done & ~err & (~hold_valid | thr_ok);
  assign accept     = tx_valid_i & tx_ready_o;

  assign init_done_o = init_done;
  assign err_o       = err;
  assign busy_o      = PSEL_o | ((state != ST_READY) && (state != ST_UNINIT));
  assign PPROT_o     = 1'b0;

  always_ff @(posedge PCLK_i) begin
    if (!PRESETn_i) begin
      state        <= ST_UNINIT;
      init_done    <= 1'b0;
      err          <= 1'b0;
      restart_pend <= 1'b0;
      hold_valid   <= 1'b0;
      hold_data    <= 8'h00;
      div_q        <= 16'h0000;
      credits      <= '0;
      poll_cnt     <= '0;
    end else begin
      if (x_done) begin
        if (x_err) begin
          err <= 1'b1;
          if (state inside {ST_INIT_LCR_DLAB, ST_INIT_DLL, ST_INIT_DLM, ST_INIT_LCR, ST_INIT_FCR}) begin
            state     <= ST_UNINIT;
            init_done <= 1'b0;
          end else begin
            hold_valid <= 1'b0;
            state      <= ST_READY;
          end
        end else begin
          case (state)
            ST_INIT_LCR_DLAB: state <= ST_INIT_DLL;
            ST_INIT_DLL:      state <= ST_INIT_DLM;
            ST_INIT_DLM:      state <= ST_INIT_LCR;
            ST_INIT_LCR:      state <= ST_INIT_FCR;
            ST_INIT_FCR: begin
              state     <= ST_READY;
              init_done <= 1'b1;
            end
            ST_POLL_LSR: begin
              if (x_rdata[LSR_THRE]) begin
                credits <= CRED_W'(FIFO_DEPTH);
                state   <= ST_WR_THR;
              end else if (poll_cnt == POLL_W'(POLL_LIMIT - 1)) begin
                err        <= 1'b1;
                hold_valid <= 1'b0;
                state      <= ST_READY;
              end else begin
                poll_cnt <= poll_cnt + POLL_W'(1);
              end
            end
            ST_WR_THR: begin
              hold_valid <= 1'b0;
              if (credits != '0) credits <= credits - CRED_W'(1);
              state <= ST_READY;
            end
            default: ;
          endcase
        end
      end else if (state == ST_READY && hold_valid) begin
        poll_cnt <= '0;
        state    <= (credits != '0) ? ST_WR_THR : ST_POLL_LSR;
      end

      if (accept) begin
        hold_valid <= 1'b1;
        hold_data  <= tx_data_i;
      end

      // Restart: the in-flight transfer (if any) completes first; the FCR write at the end
      // of init clears the UART FIFO, so credits restart from zero.
      if (cfg_start_i) begin
        err       <= 1'b0;
        init_done <= 1'b0;
        credits   <= '0;
        div_q     <= divisor_i;
      end
      if ((cfg_start_i || restart_pend) && x_idle) begin
        state        <= ST_INIT_LCR_DLAB;
        restart_pend <= 1'b0;
      end else if (cfg_start_i) begin
        restart_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_apb_tx_master.sv
// tb/tb_uart_apb_tx_master.sv - scoreboard bench for uart_apb_tx_master with a modelled APB slave
module tb_uart_apb_tx_master;

  logic        clk = 1'b0;
  logic        PRESETn_i = 1'b0;
  logic        cfg_start_i = 1'b0;
  logic [15:0] divisor_i = 16'h0000;
  logic        tx_valid_i = 1'b0;
  logic [7:0]  tx_data_i = 8'h00;
  logic        tx_ready_o, init_done_o, busy_o, err_o;
  logic [31:0] PADDR_o;
  logic        PPROT_o, PSEL_o, PENABLE_o, PWRITE_o;
  logic [31:0] PWDATA_o;
  logic [3:0]  PSTRB_o;
  logic        PREADY_i = 1'b0;
  logic [31:0] PRDATA_i = 32'h0;
  logic        PSLVERR_i = 1'b0;

  always #5 clk = ~clk;

  uart_apb_tx_master #(
    .ADDR_W(32), .DATA_W(32), .BASE_ADDR(32'h0), .FIFO_DEPTH(16), .POLL_LIMIT(8)
  ) dut (
    .PCLK_i(clk), .PRESETn_i(PRESETn_i), .cfg_start_i(cfg_start_i), .divisor_i(divisor_i),
    .tx_valid_i(tx_valid_i), .tx_data_i(tx_data_i), .tx_ready_o(tx_ready_o),
    .init_done_o(init_done_o), .busy_o(busy_o), .err_o(err_o),
    .PADDR_o(PADDR_o), .PPROT_o(PPROT_o), .PSEL_o(PSEL_o), .PENABLE_o(PENABLE_o),
    .PWRITE_o(PWRITE_o), .PWDATA_o(PWDATA_o), .PSTRB_o(PSTRB_o),
    .PREADY_i(PREADY_i), .PRDATA_i(PRDATA_i), .PSLVERR_i(PSLVERR_i)
  );

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [7:0]  data;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t e;
  int    vectors = 0;
  int    miscompares = 0;

  // slave model state
  int          wait_cycles = 0;
  int          acc_cnt = 0;
  int          dur = 0;
  int          n_xfers = 0;
  logic [7:0]  lsr_val = 8'h60;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;
  logic [31:0] s_addr, s_wdata;
  logic        s_write, stable;
  logic [3:0]  s_strb;

  function automatic void check(input string name, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endfunction

  function automatic void push(input logic w, input logic [31:0] a, input logic [7:0] d);
    exp_q.push_back('{write: w, addr: a, data: d});
  endfunction

  // APB slave + monitor: responds on the falling edge, checks each completed transfer
  always @(negedge clk) begin
    if (PSEL_o && !PENABLE_o) begin
      s_addr = PADDR_o; s_write = PWRITE_o; s_wdata = PWDATA_o; s_strb = PSTRB_o;
      stable = 1'b1; dur = 1;
    end else if (PSEL_o && PENABLE_o) begin
      dur++;
      if ({PADDR_o, PWRITE_o, PWDATA_o, PSTRB_o} !== {s_addr, s_write, s_wdata, s_strb}) stable = 1'b0;
    end
    PREADY_i  = PSEL_o && PENABLE_o && (acc_cnt >= wait_cycles);
    PSLVERR_i = PREADY_i && err_en && PWRITE_o && (PADDR_o == err_addr);
    PRDATA_i  = {4{lsr_val}};
    if (PSEL_o && PENABLE_o) acc_cnt++; else acc_cnt = 0;
    if (PREADY_i) begin
      n_xfers++;
      check("stable", stable, 1'b1);
      check("xfer_cycles", dur, 2 + wait_cycles);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_xfer: addr 0x%0h write %0d wdata 0x%0h, none expected", PADDR_o, PWRITE_o, PWDATA_o);
      end else begin
        e = exp_q.pop_front();
        check("xfer_kind", {PWRITE_o, PADDR_o}, {e.write, e.addr});
        check("pstrb", PSTRB_o, e.write ? (4'b0001 << e.addr[1:0]) : 4'b0000);
        if (e.write) check("pwdata", PWDATA_o, {4{e.data}});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_init(input logic [15:0] dv);
    int n = 0;
    push(1, 32'd3, 8'h83); push(1, 32'd0, dv[7:0]); push(1, 32'd1, dv[15:8]);
    push(1, 32'd3, 8'h03); push(1, 32'd2, 8'h07);
    @(negedge clk); divisor_i = dv; cfg_start_i = 1'b1;
    @(negedge clk); cfg_start_i = 1'b0;
    check("err_cleared", err_o, 1'b0);
    while (!init_done_o && n < 300) begin @(negedge clk); n++; end
    check("init_done", init_done_o, 1'b1);
    check("init_q_empty", exp_q.size(), 0);
    check("init_busy", busy_o, 1'b0);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk); tx_valid_i = 1'b1; tx_data_i = b; #1;
    while (!tx_ready_o && n < 500) begin @(negedge clk); #1; n++; end
    if (n >= 500) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: byte 0x%0h not accepted within 500 cycles", b);
    end
    @(posedge clk); #1; tx_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((busy_o || exp_q.size() != 0) && n < 1000) begin @(negedge clk); n++; end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int n, nx;
    tick(3);
    check("reset_outputs",
          {PADDR_o, PPROT_o, PSEL_o, PENABLE_o, PWRITE_o, PWDATA_o, PSTRB_o, tx_ready_o, init_done_o, busy_o, err_o}, '0);
    PRESETn_i = 1'b1;
    tick(2);
    check("idle_before_cfg", {PSEL_o, busy_o, init_done_o, tx_ready_o}, 4'b0000);

    // init with zero wait states, then with 3 wait states (restart from READY)
    do_init(16'h0145);
    check("tx_ready_after_init", tx_ready_o, 1'b1);
    wait_cycles = 3;
    do_init(16'h0145);
    wait_cycles = 0;

    // burst of 20 bytes: LSR read, 16 THR, LSR read, 4 THR
    lsr_val = 8'h60;
    for (int i = 0; i < 20; i++) begin
      if (i == 0 || i == 16) push(0, 32'd5, 8'h00);
      push(1, 32'd0, 8'(8'h30 + 3 * i));
    end
    for (int i = 0; i < 20; i++) send(8'(8'h30 + 3 * i));
    wait_drain("burst_q_empty");

    // poll timeout with LSR stuck at 0
    do_init(16'h0001);
    lsr_val = 8'h00;
    for (int i = 0; i < 8; i++) push(0, 32'd5, 8'h00);
    send(8'hAA);
    n = 0;
    while (!err_o && n < 300) begin @(negedge clk); n++; end
    tick(20);
    check("timeout_err", err_o, 1'b1);
    check("timeout_tx_ready", tx_ready_o, 1'b0);
    check("timeout_reads", exp_q.size(), 0);
    lsr_val = 8'h60;
    do_init(16'h0002);

    // PSLVERR on the DLM write
    err_en = 1'b1; err_addr = 32'd1;
    push(1, 32'd3, 8'h83); push(1, 32'd0, 8'h34); push(1, 32'd1, 8'h12);
    @(negedge clk); divisor_i = 16'h1234; cfg_start_i = 1'b1;
    @(negedge clk); cfg_start_i = 1'b0;
    n = 0;
    while (!err_o && n < 300) begin @(negedge clk); n++; end
    nx = n_xfers;
    tick(20);
    check("slverr_err", err_o, 1'b1);
    check("slverr_init_done", init_done_o, 1'b0);
    check("slverr_busy", {busy_o, PSEL_o}, 2'b00);
    check("slverr_no_traffic", n_xfers, nx);
    check("slverr_q_empty", exp_q.size(), 0);
    err_en = 1'b0;

    // reset during ACCESS of a THR write
    do_init(16'h0145);
    wait_cycles = 5;
    push(0, 32'd5, 8'h00);
    send(8'h5A);
    n = 0;
    while (!(PSEL_o && PENABLE_o && PWRITE_o) && n < 300) begin @(negedge clk); n++; end
    check("thr_access_reached", {PSEL_o, PENABLE_o, PWRITE_o}, 3'b111);
    PRESETn_i = 1'b0;
    @(negedge clk);
    check("midreset_outputs",
          {PADDR_o, PPROT_o, PSEL_o, PENABLE_o, PWRITE_o, PWDATA_o, PSTRB_o, tx_ready_o, init_done_o, busy_o, err_o}, '0);
    PRESETn_i = 1'b1;
    nx = n_xfers;
    tick(20);
    check("post_reset_quiet", {PSEL_o, busy_o, init_done_o}, 3'b000);
    check("post_reset_no_xfer", n_xfers, nx);
    check("post_reset_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
